// File: rtl/psrm_pkg.sv
// ---------------------------------------------------------------------------
// psrm_pkg
// Shared types and helpers for the psrm0 neuron PSP integrator.
//   psrm_state_e : integrator FSM state (INTEG / FIRE / REFRACT)
//   DT_W, DT_MAX : width and saturation value of the ticks-since-spike counter
//   SHAMT_W      : width of the log2 shift exponent produced by find_pow2_6
//   sat_add      : unsigned add with one extra carry bit, clamped to a limit
// ---------------------------------------------------------------------------
package psrm_pkg;

    typedef enum logic [1:0] {
        INTEG   = 2'd0,
        FIRE    = 2'd1,
        REFRACT = 2'd2
    } psrm_state_e;

    localparam int              DT_W    = 6;
    localparam logic [DT_W-1:0] DT_MAX  = 6'd63;
    localparam int              SHAMT_W = 3;

    // Generic width for sat_add; callers zero-extend into it and truncate
    // the result back to their own width.
    localparam int SAT_W = 32;

    // a + b computed with a carry bit, then clamped to lim so the
    // accumulator can never wrap.
    function automatic logic [SAT_W-1:0] sat_add(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b,
        input logic [SAT_W-1:0] lim
    );
        logic [SAT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, lim}) return lim;
        return sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/find_pow2_6.sv
// ---------------------------------------------------------------------------
// find_pow2_6
// Maps the 6-bit ticks-since-spike count to a right-shift exponent so the
// synaptic weight decays by a power of two as time passes.
//   dt    in  DT_W     ticks since the last accepted spike (0..63)
//   shamt out SHAMT_W  shift amount:
//         0..2 -> 0, 3..4 -> 1, 5..8 -> 2, 9..16 -> 3, 17..32 -> 4, 33..63 -> 5
// Purely combinational.
// ---------------------------------------------------------------------------
module find_pow2_6
    import psrm_pkg::*;
(
    input  logic [DT_W-1:0]    dt,
    output logic [SHAMT_W-1:0] shamt
);

    // Equivalent to max(ceil(log2(dt)) - 1, 0); written as a compare chain
    // because the bucket edges are easier to audit this way.
    always_comb begin
        shamt = 3'd5;
        if      (dt <= 6'd2)  shamt = 3'd0;
        else if (dt <= 6'd4)  shamt = 3'd1;
        else if (dt <= 6'd8)  shamt = 3'd2;
        else if (dt <= 6'd16) shamt = 3'd3;
        else if (dt <= 6'd32) shamt = 3'd4;
    end

endmodule

// File: rtl/psrm_psp_integrator.sv
// ---------------------------------------------------------------------------
// psrm_psp_integrator
// Leaky-free integrate-and-fire neuron core with power-of-two PSP decay.
// Each tick the last accepted weight, shifted right by find_pow2_6(dt),
// is added (saturating) to the membrane potential. Crossing THRESH fires a
// one-cycle spike, clears the potential and enters a refractory period.
//
// Parameters:
//   WEIGHT_W      width of the unsigned synaptic weight
//   POT_W         width of the unsigned membrane potential (>= WEIGHT_W)
//   THRESH        fire when v_mem >= THRESH
//   REFRACT_TICKS refractory length in ticks (0..15), 0 = none
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   tick       in   timestep strobe
//   in_spike   in   input spike, sampled only with tick
//   weight     in   weight of the input spike, sampled with in_spike
//   spike_out  out  one-cycle output spike
//   v_mem      out  registered membrane potential
//   refractory out  high in FIRE and REFRACT
//   in_drop    out  one-cycle pulse: a spike arrived while refractory
//
// Pipeline: tick (cycle 0) -> psp_q (cycle 1) -> v_mem (cycle 2)
//           -> spike_out (cycle 3).
// ---------------------------------------------------------------------------
module psrm_psp_integrator
    import psrm_pkg::*;
#(
    parameter int unsigned WEIGHT_W      = 8,
    parameter int unsigned POT_W         = 12,
    parameter int unsigned THRESH        = 200,
    parameter int unsigned REFRACT_TICKS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                in_spike,
    input  logic [WEIGHT_W-1:0] weight,
    output logic                spike_out,
    output logic [POT_W-1:0]    v_mem,
    output logic                refractory,
    output logic                in_drop
);

    localparam logic [POT_W-1:0] POT_MAX   = '1;
    localparam logic [POT_W-1:0] THRESH_V  = POT_W'(THRESH);
    localparam logic [3:0]       REFR_INIT = 4'(REFRACT_TICKS);

    psrm_state_e          r_state;
    logic [DT_W-1:0]      r_dt;
    logic [WEIGHT_W-1:0]  r_w_lat;
    logic                 r_active;
    logic [WEIGHT_W-1:0]  r_psp_q;
    logic                 r_psp_vld;
    logic [3:0]           r_refr_cnt;
    logic [POT_W-1:0]     r_v_mem;
    logic                 r_spike_out;
    logic                 r_refractory;
    logic                 r_in_drop;

    logic [SHAMT_W-1:0]   w_shamt;
    logic [WEIGHT_W-1:0]  w_psp;

    find_pow2_6 u_pow2 (
        .dt    (r_dt),
        .shamt (w_shamt)
    );

    // Stage-1 PSP uses the pre-update dt and latched weight.
    assign w_psp = r_w_lat >> w_shamt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= INTEG;
            r_dt         <= DT_MAX;
            r_w_lat      <= '0;
            r_active     <= 1'b0;
            r_psp_q      <= '0;
            r_psp_vld    <= 1'b0;
            r_refr_cnt   <= '0;
            r_v_mem      <= '0;
            r_spike_out  <= 1'b0;
            r_refractory <= 1'b0;
            r_in_drop    <= 1'b0;
        end else begin
            // Pulse-type signals default low; psp_vld only survives one edge.
            r_psp_vld   <= 1'b0;
            r_in_drop   <= 1'b0;
            r_spike_out <= 1'b0;

            case (r_state)
                INTEG: begin
                    // Stage 1: decayed PSP of the last accepted spike.
                    if (tick) begin
                        r_psp_q   <= w_psp;
                        r_psp_vld <= r_active;
                        if (in_spike) begin
                            r_w_lat  <= weight;
                            r_dt     <= '0;
                            r_active <= 1'b1;
                        end else if (r_dt != DT_MAX) begin
                            r_dt <= r_dt + DT_W'(1);
                        end
                    end
                    // Stage 2: saturating accumulate.
                    if (r_psp_vld) begin
                        r_v_mem <= POT_W'(sat_add(SAT_W'(r_v_mem),
                                                  SAT_W'(r_psp_q),
                                                  SAT_W'(POT_MAX)));
                    end
                    // Fire decision looks at the registered potential, so it
                    // trails the accumulate by one cycle.
                    if (r_v_mem >= THRESH_V) begin
                        r_state      <= FIRE;
                        r_spike_out  <= 1'b1;
                        r_refractory <= 1'b1;
                    end
                end

                FIRE: begin
                    // Single-cycle state; anything in flight is discarded.
                    r_v_mem    <= '0;
                    r_active   <= 1'b0;
                    r_dt       <= DT_MAX;
                    r_refr_cnt <= REFR_INIT;
                    r_in_drop  <= tick & in_spike;
                    if (REFR_INIT != 4'd0) begin
                        r_state <= REFRACT;
                    end else begin
                        r_state      <= INTEG;
                        r_refractory <= 1'b0;
                    end
                end

                REFRACT: begin
                    r_in_drop <= tick & in_spike;
                    // The tick that ends refractory is consumed here and
                    // never reaches stage 1.
                    if (tick) begin
                        r_refr_cnt <= r_refr_cnt - 4'd1;
                        if (r_refr_cnt == 4'd1) begin
                            r_state      <= INTEG;
                            r_refractory <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state      <= INTEG;
                    r_refractory <= 1'b0;
                end
            endcase
        end
    end

    assign spike_out  = r_spike_out;
    assign v_mem      = r_v_mem;
    assign refractory = r_refractory;
    assign in_drop    = r_in_drop;

endmodule

// File: tb/tb_psrm_psp_integrator.sv
module tb_psrm_psp_integrator;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       tick     = 1'b0;
    logic       in_spike = 1'b0;
    logic [7:0] weight   = 8'd0;

    // A: no-fire integrator (decay, dt saturation, reset)
    logic        spk_a, ref_a, drop_a;
    logic [11:0] v_a;
    // B: low threshold, 2-tick refractory
    logic        spk_b, ref_b, drop_b;
    logic [11:0] v_b;
    // C: 8-bit potential, saturation, no refractory
    logic        spk_c, ref_c, drop_c;
    logic [7:0]  v_c;

    int checks   = 0;
    int failures = 0;
    int nspk_a   = 0;
    int nspk_b   = 0;

    always #5 clk = ~clk;

    psrm_psp_integrator #(.WEIGHT_W(8), .POT_W(12), .THRESH(4095), .REFRACT_TICKS(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .tick(tick), .in_spike(in_spike), .weight(weight),
        .spike_out(spk_a), .v_mem(v_a), .refractory(ref_a), .in_drop(drop_a));

    psrm_psp_integrator #(.WEIGHT_W(8), .POT_W(12), .THRESH(40), .REFRACT_TICKS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .tick(tick), .in_spike(in_spike), .weight(weight),
        .spike_out(spk_b), .v_mem(v_b), .refractory(ref_b), .in_drop(drop_b));

    psrm_psp_integrator #(.WEIGHT_W(8), .POT_W(8), .THRESH(255), .REFRACT_TICKS(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .tick(tick), .in_spike(in_spike), .weight(weight),
        .spike_out(spk_c), .v_mem(v_c), .refractory(ref_c), .in_drop(drop_c));

    always @(posedge clk) begin
        if (spk_a) nspk_a <= nspk_a + 1;
        if (spk_b) nspk_b <= nspk_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One-cycle tick; returns on the negedge after the capturing posedge.
    task automatic tick_once(input logic sp, input logic [7:0] w);
        @(negedge clk);
        tick = 1'b1; in_spike = sp; weight = w;
        @(negedge clk);
        tick = 1'b0; in_spike = 1'b0; weight = 8'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int dec_exp [7] = '{16, 32, 48, 56, 64, 68, 72};
        int nb0;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        check("rst_v_a",    32'(v_a),    0);
        check("rst_spk_a",  32'(spk_a),  0);
        check("rst_ref_a",  32'(ref_a),  0);
        check("rst_drop_a", 32'(drop_a), 0);
        check("rst_v_c",    32'(v_c),    0);
        rst_n = 1'b1;

        // ---- decay profile (A), ticks 4 clocks apart ----
        tick_once(1'b1, 8'd16);
        @(negedge clk);
        check("decay_t0", 32'(v_a), 0);
        for (int i = 0; i < 7; i++) begin
            tick_once(1'b0, 8'd0);
            @(negedge clk);
            check($sformatf("decay_t%0d", i + 1), 32'(v_a), 32'(dec_exp[i]));
            @(negedge clk);
        end
        check("decay_nospike", 32'(nspk_a), 0);

        // ---- fire and latency (B) ----
        do_reset();
        nb0 = nspk_b;
        tick_once(1'b1, 8'd16);
        tick_once(1'b0, 8'd0);
        @(negedge clk);
        check("fire_v16", 32'(v_b), 16);
        tick_once(1'b0, 8'd0);
        @(negedge clk);
        check("fire_v32", 32'(v_b), 32);
        tick_once(1'b0, 8'd0);
        check("fire_c1_spk", 32'(spk_b), 0);
        @(negedge clk);
        check("fire_c2_v48", 32'(v_b), 48);
        check("fire_c2_spk", 32'(spk_b), 0);
        @(negedge clk);
        check("fire_c3_spk", 32'(spk_b), 1);
        check("fire_c3_ref", 32'(ref_b), 1);
        @(negedge clk);
        check("fire_c4_spk", 32'(spk_b), 0);
        check("fire_c4_v0",  32'(v_b),   0);
        check("fire_c4_ref", 32'(ref_b), 1);
        check("fire_count",  32'(nspk_b - nb0), 1);

        // ---- drop during refractory (B) ----
        tick_once(1'b1, 8'd50);
        check("drop_pulse", 32'(drop_b), 1);
        check("drop_ref",   32'(ref_b),  1);
        check("drop_v",     32'(v_b),    0);
        @(negedge clk);
        check("drop_clear", 32'(drop_b), 0);
        tick_once(1'b0, 8'd0);
        check("refr_end", 32'(ref_b), 0);
        @(negedge clk);
        check("refr_end_v", 32'(v_b), 0);
        tick_once(1'b1, 8'd16);
        @(negedge clk);
        check("resume_v0", 32'(v_b), 0);
        tick_once(1'b0, 8'd0);
        @(negedge clk);
        check("resume_v16", 32'(v_b), 16);

        // ---- saturation (C), tick+spike every cycle ----
        do_reset();
        tick = 1'b1; in_spike = 1'b1; weight = 8'd200;
        @(negedge clk);
        check("sat_p0_v", 32'(v_c), 0);
        @(negedge clk);
        check("sat_p1_v", 32'(v_c), 0);
        @(negedge clk);
        check("sat_p2_v", 32'(v_c), 200);
        @(negedge clk);
        check("sat_p3_v",   32'(v_c),   255);
        check("sat_p3_spk", 32'(spk_c), 0);
        @(negedge clk);
        check("sat_p4_v",   32'(v_c),   255);
        check("sat_p4_spk", 32'(spk_c), 1);
        @(negedge clk);
        check("sat_p5_v",    32'(v_c),    0);
        check("sat_p5_spk",  32'(spk_c),  0);
        check("sat_p5_drop", 32'(drop_c), 1);
        check("sat_p5_ref",  32'(ref_c),  0);
        tick = 1'b0; in_spike = 1'b0; weight = 8'd0;

        // ---- dt saturation (A): one spike then 70 ticks ----
        do_reset();
        tick_once(1'b1, 8'd255);
        @(negedge clk);
        tick = 1'b1;
        repeat (69) @(negedge clk);
        tick = 1'b0;
        repeat (2) @(negedge clk);
        check("dtsat_69", 32'(v_a), 2011);
        tick_once(1'b0, 8'd0);
        @(negedge clk);
        check("dtsat_70", 32'(v_a), 2018);

        // ---- asynchronous reset mid-pipeline (A) ----
        do_reset();
        tick_once(1'b1, 8'd100);
        tick_once(1'b0, 8'd0);
        @(negedge clk);
        check("mid_v100", 32'(v_a), 100);
        tick_once(1'b0, 8'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_v",    32'(v_a),    0);
        check("arst_spk",  32'(spk_a),  0);
        check("arst_ref",  32'(ref_a),  0);
        check("arst_drop", 32'(drop_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick_once(1'b0, 8'd0);
        repeat (2) @(negedge clk);
        check("arst_after_v", 32'(v_a), 0);

        check("a_never_fired", 32'(nspk_a), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/psrm_psp_integrator.md
Name: psrm_psp_integrator

Overview:
Downstream consumer of the 6-bit log2 shift-exponent stage (find_pow2_6) in the psrm0 neuron. It tracks ticks elapsed since the last accepted input spike and applies a power-of-two-decayed weight (weight >> exponent) to the membrane potential each tick. It fires an output spike at threshold, then enforces a refractory period. All of this runs in a fully pipelined, single-clock datapath.

Parameters:
WEIGHT_W, 8, width of the unsigned synaptic weight
POT_W, 12, width of the unsigned membrane potential; POT_W >= WEIGHT_W
THRESH, 200, firing threshold (POT_W bits, unsigned); fire when v_mem >= THRESH
REFRACT_TICKS, 4, refractory length in ticks (0..15); 0 means no refractory

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
tick  input  1  timestep strobe, one-cycle pulse
in_spike  input  1  input spike; sampled only when tick=1
weight  input  WEIGHT_W  weight of the input spike; sampled with in_spike
spike_out  output  1  one-cycle output spike
v_mem  output  POT_W  registered membrane potential
refractory  output  1  high while in FIRE or REFRACT
in_drop  output  1  one-cycle pulse; an in_spike was ignored

Behaviour:
- Reset (async, rst_n=0):
  - state=INTEG; v_mem=0; dt=63; w_lat=0; active=0; psp_q=0; psp_vld=0; refr_cnt=0.
  - All outputs 0.
  - Reset mid-pipeline discards any pending psp_q.
- Exponent: shamt = find_pow2_6(dt). Required map:
  - dt 0..2 -> 0; 3..4 -> 1; 5..8 -> 2; 9..16 -> 3; 17..32 -> 4; 33..63 -> 5.
- Stage 1, edge where tick=1 and state=INTEG:
  - psp_q <= w_lat >> shamt(dt), using the pre-update dt and w_lat.
  - psp_vld <= active.
  - Then: if in_spike, w_lat <= weight, dt <= 0, active <= 1; else dt <= min(dt+1, 63).
  - On any other edge: psp_vld <= 0.
- Stage 2, edge where psp_vld=1 and state=INTEG:
  - v_mem <= min(v_mem + psp_q, 2^POT_W-1).
  - Compute with an extra bit, then saturate; no wrap.
- Threshold, edge where state=INTEG and v_mem >= THRESH:
  - state <= FIRE.
  - Registered v_mem is compared, so stage 2 and the fire decision never combine in one cycle.
- Latency: tick in cycle 0 -> psp_q valid cycle 1 -> v_mem updated cycle 2 -> spike_out high cycle 3.
- FIRE (exactly 1 cycle):
  - spike_out=1, refractory=1.
  - Exit edge: v_mem <= 0, active <= 0, dt <= 63, psp_vld <= 0 (pending psp discarded), refr_cnt <= REFRACT_TICKS.
  - state <= REFRACT if REFRACT_TICKS>0, else INTEG.
- REFRACT:
  - refractory=1.
  - On tick: refr_cnt <= refr_cnt-1; when refr_cnt==1, state <= INTEG.
  - No psp is computed; dt holds.
- Dropped spikes: in_spike=1 with tick=1 in FIRE or REFRACT -> in_drop=1 the next cycle; the spike is otherwise ignored.
- Simultaneous events:
  - A tick in the same cycle as the stage-2 accumulate is legal; the pipeline accepts a new tick every cycle.
  - A tick on the INTEG-exit edge of REFRACT is consumed by REFRACT and does not start stage 1.
- tick without in_spike while active=0: dt advances, psp_vld=0, v_mem unchanged.
- v_mem never decreases except at FIRE exit or reset.

Decomposition:
- Package psrm_pkg:
  - state enum {INTEG, FIRE, REFRACT} (2 bits).
  - DT_W=6, DT_MAX=63.
  - Helper function sat_add.
- Sub-module: one instance of the existing find_pow2_6 (input dt, output shamt). No other sub-modules.

Test Plan:
- Decay profile: WEIGHT=16, THRESH=4095 (no fire). in_spike on tick 0, then ticks 1..7 without spikes, 4 clks apart -> v_mem sequence 16,32,48,56,64,68,72; spike_out stays 0.
- Fire and latency: THRESH=40, REFRACT_TICKS=2, weight=16 spike on tick 0.
  - Third psp gives v_mem=48; spike_out is high for exactly 1 cycle, 3 cycles after the tick.
  - Then v_mem=0 and refractory=1 for 2 further ticks.
- Drop during refractory: after a fire, in_spike with tick in REFRACT -> in_drop pulse, v_mem stays 0.
  - First spike after refractory ends -> normal integration resumes from dt=0.
- Saturation: WEIGHT_W=8, POT_W=8, THRESH=255, weight=255.
  - Back-to-back ticks each cycle -> v_mem saturates at 255 with no wrap; fires.
- dt saturation: one spike then 70 ticks (THRESH high) -> dt holds 63, psp = weight>>5; weight=255 gives 7 per tick.
- Reset mid-operation: assert rst_n=0 while psp_vld=1 and v_mem=100.
  - All outputs 0 immediately (asynchronous).
  - After release, tick without spike -> v_mem stays 0.
